// File: rtl/pipe_stages_en_flush_async_rstn.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake, global stall enable and flush.
// Empty stages keep accepting data while a later stage is stalled, so bubbles collapse.
module pipe_stages_en_flush_async_rstn #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] vld_r;
    logic [WIDTH-1:0] dat_r [DEPTH];
    logic [DEPTH:0]   rdy_s;
    logic             go_s;

    assign go_s = en & ~flush;

    // Ready chain: a stage can load when it is empty or its successor is moving.
    always_comb begin
        rdy_s        = '0;
        rdy_s[DEPTH] = out_ready & go_s;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_s[i] = (~vld_r[i] | rdy_s[i + 1]) & go_s;
        end
    end

    // Stage registers: flush outranks the enable, otherwise each ready stage takes its predecessor.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_r[i] <= RESET_VAL;
            end
        end else if (flush) begin
            vld_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_r[i] <= '0;
            end
        end else if (en) begin
            if (rdy_s[0]) begin
                vld_r[0] <= in_valid;
                dat_r[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy_s[i]) begin
                    vld_r[i] <= vld_r[i - 1];
                    dat_r[i] <= dat_r[i - 1];
                end
            end
        end else begin
            vld_r <= vld_r;
        end
    end

    // Output side: valid and data are masked while stalled or flushing; in_ready is held low in reset.
    always_comb begin
        out_valid = vld_r[DEPTH - 1] & go_s;
        if (out_valid) begin
            out_data = dat_r[DEPTH - 1];
        end else begin
            out_data = '0;
        end
        in_ready = rdy_s[0] & rstn;
    end

    // Occupancy is the raw count of valid stages, independent of en and flush.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(vld_r[i]);
        end
    end

endmodule

// File: tb/tb_pipe_stages_en_flush_async_rstn.sv
// Scoreboard bench for pipe_stages_en_flush_async_rstn (WIDTH=8, DEPTH=3, RESET_VAL=0x5A).
module tb_pipe_stages_en_flush_async_rstn;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] occupancy;

    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    logic [7:0] sb [$];
    logic       acc;
    int         lat;

    pipe_stages_en_flush_async_rstn #(
        .WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at the falling edge, observe 2 time units later, then the rising edge follows.
    task automatic tick(input logic iv, input logic [7:0] d, input logic ordy,
                        input logic e, input logic fl, output logic accepted);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        en        = e;
        flush     = fl;
        #2;
        accepted = in_valid & in_ready;
        if (accepted) sb.push_back(in_data);
        if (out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) check("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
        end
        if (!out_valid) check("out_data_masked", {24'd0, out_data}, 32'd0);
    endtask

    task automatic drain();
        logic a;
        for (int n = 0; n < 20 && (occupancy != 2'd0 || sb.size() != 0); n++)
            tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, a);
        check("drain_empty", {30'd0, occupancy}, 32'd0);
        check("drain_sb", 32'(sb.size()), 32'd0);
    endtask

    // Feed one item into an empty pipeline and measure cycles until it shows on the output.
    task automatic latency_probe(input logic [7:0] d, input string tag);
        logic a;
        int   l;
        tick(1'b1, d, 1'b1, 1'b1, 1'b0, a);
        check({tag, "_acc"}, {31'd0, a}, 32'd1);
        l = 0;
        for (int n = 1; n <= 10; n++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, a);
            if (out_valid && l == 0) l = n;
        end
        check({tag, "_lat"}, 32'(l), 32'd3);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_occ",       {30'd0, occupancy}, 32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Streaming 0x01..0x05: first output three cycles after first input, then no gaps.
        for (int k = 0; k < 8; k++) begin
            tick(k < 5, 8'(k + 1), 1'b1, 1'b1, 1'b0, acc);
            check("stream_valid", {31'd0, out_valid}, {31'd0, (k >= 3)});
            if (k == 3) check("stream_occ3", {30'd0, occupancy}, 32'd3);
        end
        drain();

        // Backpressure with a bubble, then release.
        tick(1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, acc);
        check("bp_acc_a0", {31'd0, acc}, 32'd1);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, acc);
        check("bp_acc_a1", {31'd0, acc}, 32'd1);
        tick(1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, acc);
        check("bp_acc_a2", {31'd0, acc}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, acc);
            check("bp_full_ready", {31'd0, in_ready}, 32'd0);
            check("bp_full_occ", {30'd0, occupancy}, 32'd3);
        end
        tick(1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, acc);
        check("bp_release_acc", {31'd0, acc}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, acc);
            check("bp_no_gap", {31'd0, out_valid}, 32'd1);
        end
        drain();

        // Flush a full pipeline.
        tick(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b1, 8'h22, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b1, 8'h99, 1'b1, 1'b1, 1'b1, acc);
        check("fl_occ_before", {30'd0, occupancy}, 32'd3);
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, acc);
        check("fl_occ_after", {30'd0, occupancy}, 32'd0);
        latency_probe(8'h44, "fl_next");
        drain();

        // Enable stall with two entries inside.
        tick(1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, acc);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, acc);
            check("en_out_valid", {31'd0, out_valid}, 32'd0);
            check("en_in_ready", {31'd0, in_ready}, 32'd0);
            check("en_occ", {30'd0, occupancy}, 32'd2);
        end
        drain();

        // Flush wins over a low enable.
        tick(1'b1, 8'hC0, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
        check("fle_occ_before", {30'd0, occupancy}, 32'd1);
        sb.delete();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        check("fle_occ_after", {30'd0, occupancy}, 32'd0);

        // Asynchronous reset between edges with a full pipeline.
        tick(1'b1, 8'hD1, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b1, 8'hD2, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b1, 8'hD3, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
        check("ar_occ_before", {30'd0, occupancy}, 32'd3);
        #1;
        rstn = 1'b0;
        #1;
        check("ar_occ", {30'd0, occupancy}, 32'd0);
        check("ar_out_valid", {31'd0, out_valid}, 32'd0);
        check("ar_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) check("ar_dat", {24'd0, dut.dat_r[i]}, 32'h5A);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        latency_probe(8'h77, "ar_next");
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_stages_en_flush_async_rstn.md
Name: pipe_stages_en_flush_async_rstn

Overview:
- Parametrised, elastic multi-stage pipeline register with a valid/ready handshake, a global enable (stall), and a flush.
- Generalises the single enable/flush register to DEPTH stages. Bubbles collapse, so an empty stage accepts data even while a downstream stage is stalled.
- Sits between datapath stages that need stall, kill and backpressure, for example fetch/decode buffering. A flush squashes all in-flight entries.

Parameters:
- WIDTH, 8, payload width in bits; WIDTH >= 1.
- DEPTH, 3, number of register stages; DEPTH >= 1.
- RESET_VAL, '0 (WIDTH bits), payload value loaded into every stage on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- en  input  1  global enable; 0 freezes the pipeline.
- flush  input  1  squashes all in-flight entries.
- in_valid  input  1  upstream has data.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  pipeline accepts in_data this cycle.
- out_valid  output  1  stage DEPTH-1 holds data for downstream.
- out_data  output  WIDTH  payload of stage DEPTH-1.
- out_ready  input  1  downstream accepts this cycle.
- occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- State: per stage i (0 = input side, DEPTH-1 = output side), registers vld[i] and dat[i].
- Reset: asserting rstn low clears every vld[i] to 0 and loads every dat[i] with RESET_VAL, immediately and regardless of clk. Outputs during reset: out_valid=0, out_data=0, occupancy=0, in_ready=0.
- Transfer definitions:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Ready chain, combinational:
  - rdy[DEPTH] = out_ready & en & ~flush.
  - rdy[i] = (~vld[i] | rdy[i+1]) & en & ~flush.
  - in_ready = rdy[0].
- Stage update when en=1 and flush=0:
  - If rdy[i], stage i loads vld[i-1]/dat[i-1]; stage 0 loads in_valid/in_data.
  - Otherwise stage i holds.
  - Data of a stage loaded with vld=0 is don't-care internally, but is never visible on out_data.
- en=0 and flush=0: all state holds; in_ready=0; out_valid=0 (masked, no transfer).
- Flush:
  - Flush has priority over en.
  - While flush=1, out_valid=0, out_data=0 and in_ready=0, combinationally in the same cycle.
  - At the next edge every vld[i]←0 and dat[i]←0.
  - A flush held for N cycles keeps the pipeline empty for N cycles.
- out_valid = vld[DEPTH-1] & en & ~flush.
- out_data = out_valid ? dat[DEPTH-1] : 0.
- occupancy = popcount(vld), unmasked by en and masked to 0 by neither. It reflects the registered state.
- Latency: with no stalls, in_data accepted at cycle t appears on out_data at cycle t+DEPTH.
- Throughput: 1 transfer per cycle when out_ready=1.
- Ordering: strictly FIFO; no duplication or loss except by flush.
- Full pipeline (occupancy=DEPTH) with out_ready=0: in_ready=0.
- Full pipeline with out_ready=1: in_ready=1. Simultaneous input and output transfer; occupancy unchanged.
- Empty pipeline: out_valid=0. An input transfer makes occupancy=1 at the next edge.
- Bubble collapse: with out_ready=0 and a gap at stage k, upstream entries advance into the gap. in_ready stays 1 until every stage is valid.
- Flush and input transfer in the same cycle: impossible, because in_ready=0 during flush; in_valid is ignored.
- Reset mid-operation: all entries are lost. The first input transfer after rstn deasserts behaves as on an empty pipeline.
- The ready path is combinational from out_ready through DEPTH stages to in_ready. This is accepted by design for DEPTH <= 8.

Test Plan:
- Streaming, WIDTH=8, DEPTH=3, en=1, out_ready=1: feed 0x01..0x05 on consecutive cycles → out_data 0x01..0x05 on consecutive cycles, first at +3 cycles; occupancy reaches 3.
- Backpressure with bubble collapse: hold out_ready=0 and send 0xA0, idle 1 cycle, then 0xA1, 0xA2, 0xA3 → 0xA0..0xA2 accepted, in_ready drops once occupancy=3, 0xA3 held upstream. Release out_ready → output order 0xA0, 0xA1, 0xA2, 0xA3 with no gaps.
- Flush mid-stream: with occupancy=3 holding 0x11, 0x22, 0x33, pulse flush for 1 cycle → same cycle out_valid=0, out_data=0, in_ready=0; next cycle occupancy=0. The next input 0x44 emerges after 3 cycles.
- Enable stall: with occupancy=2, drive en=0 for 4 cycles and out_ready=1 → out_valid=0, in_ready=0, occupancy stays 2. Restoring en=1 resumes output in the original order.
- Flush beats enable: drive en=0 and flush=1 together → occupancy=0 next cycle.
- Asynchronous reset: with occupancy=3 and RESET_VAL=0x5A, drop rstn between clock edges → occupancy=0 and out_valid=0 immediately, internal dat=0x5A. Release rstn, feed 0x77 → 0x77 appears after 3 cycles.
